// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line descriptor scan filling up to MAX_SLOTS sprite slots.
// Optional SPRITE_SCHED_OVERFLOW_EN enables the overflow flag and saturating ovf_count.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 30,
    parameter int MAX_SLOTS   = 8,
    parameter int SPRITE_H    = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [9:0]  line_num,
    output logic [4:0]  desc_addr,
    input  logic [31:0] desc_data,
    output logic        slot_we,
    output logic [2:0]  slot_idx,
    output logic [20:0] slot_data,
    output logic [3:0]  slot_count,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  ovf_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state, state_nx;
    logic [9:0] ln, diff;
    logic       fin, pv, hit, accept, unused_bits;
    logic [3:0] hits;
    assign accept      = state == IDLE && line_start;
    assign diff        = ln - desc_data[9:0];
    // pv marks that desc_data holds the descriptor addressed one cycle earlier
    assign hit         = pv && desc_data[31:26] != 6'd0 && diff < 10'(SPRITE_H);
    assign slot_we     = hit && hits < 4'(MAX_SLOTS);
    assign slot_idx    = hits[2:0];
    assign slot_data   = slot_we ? {desc_data[31:16], diff[4:0]} : '0;
    assign unused_bits = ^desc_data[15:10];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = accept ? SCAN :
                   (state == SCAN && fin) ? DRAIN :
                   (state == DRAIN) ? IDLE : state;
    end
    always_comb begin
        busy = state != IDLE;
        done = state == DRAIN;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            desc_addr  <= '0;
            fin        <= 1'b0;
            pv         <= 1'b0;
            hits       <= '0;
            ln         <= '0;
            slot_count <= '0;
        end else begin
            pv <= state == SCAN && !fin;
            if (accept) begin
                ln        <= line_num;
                desc_addr <= '0;
                fin       <= 1'b0;
                hits      <= '0;
            end else if (state == SCAN) begin
                if (!fin) begin
                    if (desc_addr == 5'(NUM_SPRITES - 1)) fin <= 1'b1;
                    else desc_addr <= desc_addr + 5'd1;
                end else begin
                    desc_addr  <= '0;
                    slot_count <= hits + {3'd0, slot_we};
                end
                if (slot_we) hits <= hits + 4'd1;
            end
        end
    end
`ifdef SPRITE_SCHED_OVERFLOW_EN
    logic ovfl, miss;
    assign miss = hit && !slot_we;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovfl      <= 1'b0;
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (accept) begin
            ovfl     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == SCAN) begin
            if (miss) ovfl <= 1'b1;
            if (fin) begin
                overflow <= ovfl || miss;
                if ((ovfl || miss) && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign ovf_count = '0;
`endif
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed and randomized scans against a descriptor-level reference model.
module tb_sprite_line_scheduler;
    logic        clk = 0, reset_n = 0, line_start = 0;
    logic [9:0]  line_num = 0;
    logic [4:0]  desc_addr;
    logic [31:0] desc_data;
    logic        slot_we, busy, done, overflow;
    logic [2:0]  slot_idx;
    logic [20:0] slot_data;
    logic [3:0]  slot_count;
    logic [7:0]  ovf_count;

    sprite_line_scheduler dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_num(line_num),
        .desc_addr(desc_addr), .desc_data(desc_data), .slot_we(slot_we), .slot_idx(slot_idx),
        .slot_data(slot_data), .slot_count(slot_count), .busy(busy), .done(done),
        .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    always @(posedge clk) desc_data <= mem[desc_addr];

    int errors = 0, checks = 0;
    int m_sc = 0, m_ovc = 0;
    bit m_ovf = 0;
    bit          e_we   [40];
    int          e_idx  [40];
    logic [20:0] e_data [40];
    int          e_cnt;
    bit          e_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk descriptors in order; first 8 hits land in slots, later hits only flag overflow.
    function automatic void model(input logic [9:0] ln);
        int n = 0;
        for (int c = 0; c < 40; c++) begin
            e_we[c] = 0; e_idx[c] = 0; e_data[c] = '0;
        end
        e_ovf = 0;
        for (int k = 0; k < 30; k++) begin
            logic [5:0] id;
            logic [9:0] d;
            id = mem[k][31:26];
            d  = ln - mem[k][9:0];
            if (id != 0 && d < 32) begin
                if (n < 8) begin
                    e_we[k+2]   = 1;
                    e_idx[k+2]  = n;
                    e_data[k+2] = {id, mem[k][25:16], d[4:0]};
                    n++;
                end else e_ovf = 1;
            end
        end
        e_cnt = n;
    endfunction

    task automatic run_scan(input logic [9:0] ln, input int ign, input int rc);
        model(ln);
        line_num = ln;
        line_start = 1;
        @(negedge clk);
        line_start = 0;
        for (int c = 1; c <= 34; c++) begin
            if (c == rc) begin
                reset_n = 0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_we", slot_we, 0);
                chk("rst_done", done, 0);
                chk("rst_addr", desc_addr, 0);
                chk("rst_count", slot_count, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_hold_done", done, 0);
                    chk("rst_hold_we", slot_we, 0);
                    chk("rst_hold_busy", busy, 0);
                end
                reset_n = 1;
                m_sc = 0; m_ovf = 0; m_ovc = 0;
                @(negedge clk);
                chk("post_rst_done", done, 0);
                return;
            end
            chk("busy", busy, c <= 32);
            chk("done", done, c == 32);
            chk("slot_we", slot_we, e_we[c]);
            if (e_we[c]) begin
                chk("slot_idx", slot_idx, e_idx[c]);
                chk("slot_data", slot_data, e_data[c]);
            end
            if (c <= 30) chk("desc_addr", desc_addr, c - 1);
            if (c == 1) begin
                chk("count_hold", slot_count, m_sc);
                chk("ovf_clear", overflow, 0);
            end
            if (c == 32) begin
                m_sc = e_cnt;
`ifdef SPRITE_SCHED_OVERFLOW_EN
                m_ovf = e_ovf;
                if (e_ovf && m_ovc < 255) m_ovc++;
`endif
                chk("slot_count", slot_count, m_sc);
                chk("overflow", overflow, m_ovf);
                chk("ovf_count", ovf_count, m_ovc);
            end
            if (c == 34) chk("idle_addr", desc_addr, 0);
            if (c == ign) begin
                line_start = 1;
                line_num = ~ln;
            end else line_start = 0;
            @(negedge clk);
        end
        line_start = 0;
    endtask

    function automatic logic [31:0] desc(input logic [5:0] id, input logic [9:0] x, input logic [9:0] y);
        return {id, x, 6'($urandom_range(0, 63)), y};
    endfunction

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = '0;
        #2;
        chk("reset_addr", desc_addr, 0);
        chk("reset_we", slot_we, 0);
        chk("reset_idx", slot_idx, 0);
        chk("reset_data", slot_data, 0);
        chk("reset_count", slot_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_ovfc", ovf_count, 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        run_scan(10'd100, 0, 0);

        mem[3] = desc(6'd5, 10'd200, 10'd90);
        run_scan(10'd100, 0, 0);

        for (int k = 0; k < 32; k++) mem[k] = '0;
        mem[0] = desc(6'd1, 10'd11, 10'd100);
        mem[1] = desc(6'd2, 10'd22, 10'd69);
        mem[2] = desc(6'd3, 10'd33, 10'd68);
        mem[3] = desc(6'd4, 10'd44, 10'd101);
        run_scan(10'd100, 0, 0);

        for (int k = 0; k < 32; k++) mem[k] = '0;
        mem[0] = desc(6'd9, 10'd1, 10'd1000);
        mem[1] = desc(6'd10, 10'd2, 10'd6);
        run_scan(10'd5, 0, 0);

        for (int k = 0; k < 30; k++) mem[k] = desc(6'(k + 1), 10'(k * 7), 10'd500);
        run_scan(10'd500, 0, 0);
        run_scan(10'd500, 10, 0);
        run_scan(10'd500, 0, 15);
        run_scan(10'd510, 0, 0);

        repeat (8) begin
            logic [9:0] ln;
            ln = 10'($urandom_range(0, 1023));
            for (int k = 0; k < 30; k++) begin
                logic [5:0] id;
                id = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
                mem[k] = desc(id, 10'($urandom_range(0, 1023)), ln - 10'($urandom_range(0, 45)));
            end
            run_scan(ln, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
